// File: rtl/button_pattern_gen_if.sv
// Handshake bundle between the pattern generator and its driver.
// Carries run control in and emulated button lines / run status out.
interface button_pattern_gen_if #(
    parameter int REP_W = 4
);
    logic             start;
    logic             abort;
    logic [REP_W-1:0] repeat_n;
    logic             btn3_n;
    logic             btn4_n;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] seq_cnt;

    modport master (
        output start, abort, repeat_n,
        input  btn3_n, btn4_n, busy, done, seq_cnt
    );

    modport slave (
        input  start, abort, repeat_n,
        output btn3_n, btn4_n, busy, done, seq_cnt
    );
endinterface

// File: rtl/button_pattern_gen.sv
// Emulates button 3 then button 4 press/release, repeated per run,
// on active-low registered lines with fixed press and gap widths.
module button_pattern_gen #(
    parameter int PRESS_CYCLES = 2_700_000,
    parameter int GAP_CYCLES   = 2_700_000,
    parameter int CNT_W        = 24,
    parameter int REP_W        = 4
) (
    input logic                clk,
    input logic                rst,
    button_pattern_gen_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        P3,
        G3,
        P4,
        G4
    } state_e;

    localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             btn3_n_q, btn3_n_d;
    logic             btn4_n_q, btn4_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REP_W:0]   seq_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        seq_cnt_d = seq_cnt_q;
        done_d    = 1'b0;
        seq_nxt   = {1'b0, seq_cnt_q} + (REP_W+1)'(1);

        if (state_q == IDLE) begin
            if (bus.start && !bus.abort) begin
                state_d   = P3;
                cnt_d     = PRESS_LD;
                seq_cnt_d = '0;
                rep_d     = (bus.repeat_n == '0) ? REP_W'(1)
                                                 : bus.repeat_n;
            end
        end else if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                P3: begin
                    state_d = G3;
                    cnt_d   = GAP_LD;
                end
                G3: begin
                    state_d = P4;
                    cnt_d   = PRESS_LD;
                end
                P4: begin
                    state_d = G4;
                    cnt_d   = GAP_LD;
                end
                G4: begin
                    seq_cnt_d = seq_nxt[REP_W-1:0];
                    if (seq_nxt < {1'b0, rep_q}) begin
                        state_d = P3;
                        cnt_d   = PRESS_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they leave straight from flops
        btn3_n_d = (state_d != P3);
        btn4_n_d = (state_d != P4);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rep_q     <= '0;
            seq_cnt_q <= '0;
            btn3_n_q  <= 1'b1;
            btn4_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            seq_cnt_q <= seq_cnt_d;
            btn3_n_q  <= btn3_n_d;
            btn4_n_q  <= btn4_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.btn3_n  = btn3_n_q;
    assign bus.btn4_n  = btn4_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.seq_cnt = seq_cnt_q;
endmodule

// File: tb/tb_button_pattern_gen.sv
// Directed bench for button_pattern_gen with PRESS=3, GAP=2.
// Outputs packed as {btn3_n, btn4_n, busy, done, seq_cnt[3:0]}.
module tb_button_pattern_gen;
    localparam int P = 3;
    localparam int G = 2;
    localparam int SEQ = 2 * (P + G);

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   det_cnt;
    int   det_st;
    int   det_len;
    int   det_snap;

    button_pattern_gen_if #(.REP_W(4)) bus ();

    button_pattern_gen #(
        .PRESS_CYCLES(P),
        .GAP_CYCLES  (G),
        .CNT_W       (24),
        .REP_W       (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && !bus.btn3_n && !bus.btn4_n) begin
            n_total++;
            $error("FAIL overlap obs=both_low exp=not_both_low");
        end
    end

    // Reference detector: 3-cycle btn3 press, then 3-cycle btn4 press
    always @(negedge clk) begin
        if (rst) begin
            det_st  = 0;
            det_len = 0;
        end else begin
            case (det_st)
                0: if (!bus.btn3_n) begin det_st = 1; det_len = 1; end
                1: if (!bus.btn3_n) det_len++;
                   else det_st = (det_len == P) ? 2 : 0;
                2: if (!bus.btn4_n) begin det_st = 3; det_len = 1; end
                   else if (!bus.btn3_n) begin det_st = 1; det_len = 1; end
                3: if (!bus.btn4_n) det_len++;
                   else begin
                       if (det_len == P) det_cnt++;
                       det_st = 0;
                   end
                default: det_st = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bus.btn3_n, bus.btn4_n, bus.busy, bus.done,
                bus.seq_cnt};
    endfunction

    function automatic logic [31:0] pack(input logic b3, input logic b4,
                                         input logic bz, input logic dn,
                                         input int s);
        return {24'd0, b3, b4, bz, dn, 4'(s)};
    endfunction

    // Called in the first press cycle; returns in the done cycle.
    task automatic expect_run(input string tag, input int r,
                              input int poke);
        int ph;
        logic b3;
        logic b4;
        for (int i = 0; i < r * SEQ; i++) begin
            ph = i % SEQ;
            b3 = !(ph < P);
            b4 = !(ph >= P + G && ph < 2 * P + G);
            chk($sformatf("%s_c%0d", tag, i), outs(),
                pack(b3, b4, 1'b1, 1'b0, i / SEQ));
            if (i == poke) begin
                bus.start    = 1'b1;
                bus.repeat_n = 4'd9;
            end
            step();
            bus.start = 1'b0;
        end
        chk({tag, "_done"}, outs(), pack(1, 1, 0, 1, r));
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        det_cnt      = 0;
        det_st       = 0;
        det_len      = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.repeat_n = 4'd0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("reset_idle", outs(), pack(1, 1, 0, 0, 0));

        // Single sequence
        det_snap     = det_cnt;
        bus.repeat_n = 4'd1;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_run("r1", 1, -1);
        step();
        chk("r1_after", outs(), pack(1, 1, 0, 0, 1));
        chk("r1_det", det_cnt - det_snap, 1);

        // repeat_n = 0 behaves as 1
        det_snap     = det_cnt;
        bus.repeat_n = 4'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_run("r0", 1, -1);
        step();
        chk("r0_det", det_cnt - det_snap, 1);

        // Three sequences; mid-run start and repeat change ignored
        det_snap     = det_cnt;
        bus.repeat_n = 4'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_run("r3", 3, 7);
        chk("r3_det", det_cnt - det_snap, 3);

        // start in the done cycle launches immediately
        bus.repeat_n = 4'd1;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_run("b2b", 1, -1);
        step();
        chk("b2b_after", outs(), pack(1, 1, 0, 0, 1));

        // Abort during the second P4 of a 3-repeat run
        bus.repeat_n = 4'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < SEQ + P + G + 1; i++) step();
        chk("ab_pre", outs(), pack(1, 0, 1, 0, 1));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_post", outs(), pack(1, 1, 0, 0, 1));
        step();
        chk("ab_nodone1", outs(), pack(1, 1, 0, 0, 1));
        step();
        chk("ab_nodone2", outs(), pack(1, 1, 0, 0, 1));

        // abort and start together in IDLE: no run
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("ab_st1", outs(), pack(1, 1, 0, 0, 1));
        step();
        chk("ab_st2", outs(), pack(1, 1, 0, 0, 1));

        // Reset while btn4 is pressed
        bus.repeat_n = 4'd2;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < P + G; i++) step();
        chk("rst_pre", outs(), pack(1, 0, 1, 0, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_post", outs(), pack(1, 1, 0, 0, 0));
        step();
        chk("rst_idle", outs(), pack(1, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
